lane_shooter_core: RTL

Parametrised game engine for the LCD target-shooting game. It keeps a COLS-deep queue of targets drawn from an LFSR across LANES lanes, and judges one-cycle button pulses against the queue head. It keeps a BCD score and a retained high score, and runs a countdown with a miss penalty. It sits between the debounce/edge-detect front end and the LCD row formatter, and has no display or debounce logic of its own.

---
 rtl/lane_shooter_core.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lane_shooter_core.sv
// lane_shooter_core
//
// Game engine for the LCD target-shooting game. A COLS-deep queue of targets
// is filled from a 16-bit Galois LFSR; one-cycle button pulses are judged
// against the queue head while a per-second countdown runs. The block keeps a
// BCD score and a high score retained across rounds (cleared only by reset).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; clears everything incl. high score
//   btn_pressed  one-cycle press pulses, bit i = lane i
//   start        pulse; WAIT -> PLAY
//   restart      pulse; OVER -> FILL
//   state        IDLE=0, FILL=1, WAIT=2, PLAY=3, OVER=4
//   queue        target lanes, entry k at [k*LB +: LB], entry 0 is the head
//   sec_left     seconds remaining in the round
//   score_bcd    current score, digit 0 in the low nibble
//   high_bcd     best finished score since reset
//   hit, miss    one-cycle judgement pulses
//   new_high     level; last round beat the previous high score
module lane_shooter_core #(
    parameter int          LANES         = 2,
    parameter int          COLS          = 16,
    parameter int          PLAY_SEC      = 10,
    parameter int          TICKS_PER_SEC = 100_000_000,
    parameter int          SCORE_DIGITS  = 3,
    parameter int          PENALTY_SEC   = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         LB            = $clog2(LANES),
    localparam int         SW            = $clog2(PLAY_SEC + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0]          btn_pressed,
    input  logic                      start,
    input  logic                      restart,
    output logic [2:0]                state,
    output logic [COLS*LB-1:0]        queue,
    output logic [SW-1:0]             sec_left,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [4*SCORE_DIGITS-1:0] high_bcd,
    output logic                      hit,
    output logic                      miss,
    output logic                      new_high
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_PLAY = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int SD = 4 * SCORE_DIGITS;
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int FW = (COLS > 1) ? $clog2(COLS) : 1;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [SD-1:0]    SCORE_MAX = {SCORE_DIGITS{4'h9}};
    localparam logic [LANES-1:0] LANE_ONE  = {{(LANES-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    SEC_FULL  = SW'(PLAY_SEC);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [FW-1:0]    FILL_LAST = FW'(COLS - 1);

    // One Galois LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        if (v[0]) begin
            r = {1'b0, v[15:1]} ^ LFSR_TAPS;
        end else begin
            r = {1'b0, v[15:1]};
        end
        return r;
    endfunction

    // BCD increment with ripple carry; an all-nines score saturates.
    function automatic logic [SD-1:0] bcd_inc(input logic [SD-1:0] v);
        logic [SD-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        if (v == SCORE_MAX) begin
            r = v;
        end else begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'h9) begin
                        r[4*i +: 4] = 4'h0;
                        carry       = 1'b1;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'h1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[4*i +: 4] = v[4*i +: 4];
                end
            end
        end
        return r;
    endfunction

    // Seconds minus the combined tick/penalty amount, floored at zero.
    function automatic logic [SW-1:0] sec_sat_sub(input logic [SW-1:0] sec,
                                                  input logic [31:0]   sub);
        logic [31:0]   sec_w;
        logic [SW-1:0] r;
        sec_w = 32'(sec);
        if (sub >= sec_w) begin
            r = '0;
        end else begin
            r = SW'(sec_w - sub);
        end
        return r;
    endfunction

    state_t               state_q,    state_d;
    logic [COLS*LB-1:0]   queue_q,    queue_d;
    logic [SW-1:0]        sec_q,      sec_d;
    logic [SD-1:0]        score_q,    score_d;
    logic [SD-1:0]        high_q,     high_d;
    logic                 hit_q,      hit_d;
    logic                 miss_q,     miss_d;
    logic                 new_high_q, new_high_d;
    logic [15:0]          lfsr_q,     lfsr_d;
    logic [TW-1:0]        tick_q,     tick_d;
    logic [FW-1:0]        fill_q,     fill_d;

    logic [LB-1:0]        new_lane_s;
    logic [LB-1:0]        head_s;
    logic [COLS*LB-1:0]   shifted_s;
    logic [LANES-1:0]     hit_sel_s;
    logic [31:0]          sec_sub_s;

    // Next-state, judging, scoring and countdown logic.
    always_comb begin
        state_d    = state_q;
        queue_d    = queue_q;
        sec_d      = sec_q;
        score_d    = score_q;
        high_d     = high_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        new_high_d = new_high_q;
        tick_d     = tick_q;
        fill_d     = fill_q;
        sec_sub_s  = 32'd0;

        lfsr_d     = lfsr_step(lfsr_q);
        new_lane_s = lfsr_q[LB-1:0];
        head_s     = queue_q[LB-1:0];
        // Queue moves toward the head; the fresh target lands in the tail.
        shifted_s  = {new_lane_s, queue_q[COLS*LB-1:LB]};
        // The only press pattern that counts as a hit: exactly the head lane.
        hit_sel_s  = LANE_ONE << head_s;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FILL;
                fill_d     = '0;
                score_d    = '0;
                new_high_d = 1'b0;
                sec_d      = SEC_FULL;
            end
            ST_FILL: begin
                queue_d = shifted_s;
                if (fill_q == FILL_LAST) begin
                    state_d = ST_WAIT;
                    fill_d  = fill_q;
                end else begin
                    state_d = ST_FILL;
                    fill_d  = fill_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (start) begin
                    state_d = ST_PLAY;
                    tick_d  = '0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PLAY: begin
                if (sec_q == '0) begin
                    // Final PLAY cycle: settle the round, presses no longer count.
                    state_d = ST_OVER;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        high_d     = high_q;
                    end
                end else begin
                    if (btn_pressed == '0) begin
                        sec_sub_s = 32'd0;
                    end else if (btn_pressed == hit_sel_s) begin
                        hit_d   = 1'b1;
                        score_d = bcd_inc(score_q);
                        queue_d = shifted_s;
                    end else begin
                        miss_d    = 1'b1;
                        sec_sub_s = 32'(PENALTY_SEC);
                    end
                    // A tick and a penalty in one cycle add up before flooring.
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        sec_sub_s = sec_sub_s + 32'd1;
                    end else begin
                        tick_d    = tick_q + 1'b1;
                    end
                    sec_d = sec_sat_sub(sec_q, sec_sub_s);
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d    = ST_FILL;
                    fill_d     = '0;
                    score_d    = '0;
                    new_high_d = 1'b0;
                    sec_d      = SEC_FULL;
                end else begin
                    state_d    = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            queue_q    <= '0;
            sec_q      <= SEC_FULL;
            score_q    <= '0;
            high_q     <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            new_high_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            tick_q     <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            queue_q    <= queue_d;
            sec_q      <= sec_d;
            score_q    <= score_d;
            high_q     <= high_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            new_high_q <= new_high_d;
            lfsr_q     <= lfsr_d;
            tick_q     <= tick_d;
            fill_q     <= fill_d;
        end
    end

    assign state     = state_q;
    assign queue     = queue_q;
    assign sec_left  = sec_q;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign new_high  = new_high_q;

endmodule
